// File: rtl/ex.sv
// ex: MIPS execute stage with combinational ALU and a multi-cycle restoring divider.
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);
  localparam logic [2:0] SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_MOVE = 3'd3,
                         SEL_ARITH = 3'd4, SEL_DIV = 3'd5;
  localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27,
                         OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03,
                         OP_SLT = 8'h2A, OP_SLTU = 8'h2B, OP_ADD = 8'h20, OP_ADDU = 8'h21,
                         OP_SUB = 8'h22, OP_SUBU = 8'h23, OP_MFHI = 8'h10, OP_MFLO = 8'h12,
                         OP_DIV = 8'h1A, OP_DIVU = 8'h1B;
  typedef enum logic [1:0] {IDLE, ON, ZERO, END} state_t;
  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] q, rem, dvs, sum, logic_res, shift_res, arith_res, move_res;
  logic [32:0] rs;
  logic        qneg, rneg, ge, sub, ovf, is_div, sgn;
  assign sub = aluop_i == OP_SUB || aluop_i == OP_SUBU;
  assign sum = reg1_i + (sub ? ~reg2_i : reg2_i) + {31'b0, sub};
  // signed overflow: operands (after subtrahend inversion) agree in sign but the sum does not
  assign ovf = alusel_i == SEL_ARITH && (aluop_i == OP_ADD || aluop_i == OP_SUB) &&
               ((reg1_i[31] ~^ reg2_i[31]) ^ sub) && (sum[31] ^ reg1_i[31]);
  assign logic_res = aluop_i == OP_OR  ? reg1_i | reg2_i :
                     aluop_i == OP_AND ? reg1_i & reg2_i :
                     aluop_i == OP_XOR ? reg1_i ^ reg2_i :
                     aluop_i == OP_NOR ? ~(reg1_i | reg2_i) : 32'b0;
  assign shift_res = aluop_i == OP_SLL ? reg2_i << reg1_i[4:0] :
                     aluop_i == OP_SRL ? reg2_i >> reg1_i[4:0] :
                     aluop_i == OP_SRA ? 32'($signed(reg2_i) >>> reg1_i[4:0]) : 32'b0;
  assign arith_res = (aluop_i == OP_ADD || aluop_i == OP_ADDU || sub) ? sum :
                     aluop_i == OP_SLT  ? {31'b0, $signed(reg1_i) < $signed(reg2_i)} :
                     aluop_i == OP_SLTU ? {31'b0, reg1_i < reg2_i} : 32'b0;
  assign move_res  = aluop_i == OP_MFHI ? hi_i : aluop_i == OP_MFLO ? lo_i : 32'b0;
  assign wdata_o = rst ? 32'b0 :
                   alusel_i == SEL_LOGIC ? logic_res :
                   alusel_i == SEL_SHIFT ? shift_res :
                   alusel_i == SEL_ARITH ? arith_res :
                   alusel_i == SEL_MOVE  ? move_res : 32'b0;
  assign waddr_o = rst ? 5'b0 : waddr_i;
  assign we_o    = !rst && we_i && alusel_i != SEL_DIV && !ovf;
  assign is_div  = alusel_i == SEL_DIV && (aluop_i == OP_DIV || aluop_i == OP_DIVU);
  assign sgn     = aluop_i == OP_DIV;
  assign rs      = {rem, q[31]};
  assign ge      = rs >= {1'b0, dvs};
  assign stallreq_o = !rst && is_div && state != END;
  assign whilo_o    = !rst && state == END;
  assign lo_o = whilo_o ? (qneg ? -q : q) : 32'b0;
  assign hi_o = whilo_o ? (rneg ? -rem : rem) : 32'b0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else
      case (state)
        IDLE: if (is_div) begin
          cnt <= 6'd0;
          if (reg2_i == 32'b0) state <= ZERO;
          else begin
            state <= ON;
            q     <= sgn && reg1_i[31] ? -reg1_i : reg1_i;
            dvs   <= sgn && reg2_i[31] ? -reg2_i : reg2_i;
            rem   <= 32'b0;
            qneg  <= sgn && (reg1_i[31] ^ reg2_i[31]);
            rneg  <= sgn && reg1_i[31];
          end
        end
        ON: begin
          rem <= ge ? 32'(rs - {1'b0, dvs}) : rs[31:0];
          q   <= {q[30:0], ge};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= END;
        end
        ZERO: begin
          q     <= 32'b0;
          rem   <= 32'b0;
          qneg  <= 1'b0;
          rneg  <= 1'b0;
          state <= END;
        end
        END: state <= IDLE;
      endcase
endmodule

// File: tb/tb_ex.sv
// tb_ex: randomized scoreboard bench for the ex stage against an arithmetic reference model.
module tb_ex;
  localparam logic [2:0] S_NOP = 3'd0, S_LOGIC = 3'd1, S_SHIFT = 3'd2, S_MOVE = 3'd3,
                         S_ARITH = 3'd4, S_DIV = 3'd5;
  localparam logic [7:0] O_AND = 8'h24, O_OR = 8'h25, O_XOR = 8'h26, O_NOR = 8'h27,
                         O_SLL = 8'h7C, O_SRL = 8'h02, O_SRA = 8'h03,
                         O_SLT = 8'h2A, O_SLTU = 8'h2B, O_ADD = 8'h20, O_ADDU = 8'h21,
                         O_SUB = 8'h22, O_SUBU = 8'h23, O_MFHI = 8'h10, O_MFLO = 8'h12,
                         O_DIV = 8'h1A, O_DIVU = 8'h1B;
  typedef struct {logic [31:0] wdata; logic we; logic [4:0] waddr; logic care;} comb_t;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int lat;} div_t;

  logic clk = 0, rst = 1;
  logic [7:0] aluop = 0;
  logic [2:0] alusel = 0;
  logic [31:0] reg1 = 0, reg2 = 0, hi = 0, lo = 0;
  logic [4:0] waddr = 0;
  logic we = 0, cv = 0;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic [4:0] waddr_o;
  logic we_o, whilo_o, stallreq_o;
  int checks = 0, failures = 0, done_cnt = 0, dcyc = 0, dstall = 0;
  comb_t comb_q[$];
  div_t div_q[$];

  ex dut (.clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel), .reg1_i(reg1),
          .reg2_i(reg2), .waddr_i(waddr), .we_i(we), .hi_i(hi), .lo_i(lo),
          .wdata_o(wdata_o), .waddr_o(waddr_o), .we_o(we_o), .whilo_o(whilo_o),
          .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o));

  always #5 clk = ~clk;

  function automatic comb_t cmodel(input logic [7:0] op, input logic [2:0] sel,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] h, input logic [31:0] l,
                                   input logic w, input logic [4:0] wa);
    comb_t r;
    longint sa, sb, s, p;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(a[4:0]);
    p = longint'(1) << sh;
    r.wdata = 0; r.we = w; r.waddr = wa; r.care = 1;
    s = 0;
    if (sel == S_LOGIC)
      r.wdata = op == O_OR ? a | b : op == O_AND ? a & b : op == O_XOR ? a ^ b :
                op == O_NOR ? ~(a | b) : 32'b0;
    else if (sel == S_SHIFT) begin
      if (op == O_SLL) begin s = longint'({32'b0, b}) * p; r.wdata = s[31:0]; end
      else if (op == O_SRL) begin s = longint'({32'b0, b}) / p; r.wdata = s[31:0]; end
      else if (op == O_SRA) begin
        s = sb / p;
        if (sb < 0 && sb % p != 0) s = s - 1;
        r.wdata = s[31:0];
      end
    end else if (sel == S_ARITH) begin
      if (op == O_ADD || op == O_ADDU) s = sa + sb;
      else if (op == O_SUB || op == O_SUBU) s = sa - sb;
      if (op == O_ADD || op == O_ADDU || op == O_SUB || op == O_SUBU) r.wdata = s[31:0];
      else if (op == O_SLT) r.wdata = sa < sb ? 32'd1 : 32'd0;
      else if (op == O_SLTU) r.wdata = longint'({32'b0, a}) < longint'({32'b0, b}) ? 32'd1 : 32'd0;
      if ((op == O_ADD || op == O_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648)) begin
        r.we = 0; r.care = 0;
      end
    end else if (sel == S_MOVE)
      r.wdata = op == O_MFHI ? h : op == O_MFLO ? l : 32'b0;
    return r;
  endfunction

  function automatic div_t dmodel(input logic s, input logic [31:0] a, input logic [31:0] b);
    div_t r;
    longint x, y, qq, rr;
    x = s ? longint'($signed(a)) : longint'({32'b0, a});
    y = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (y == 0) begin r.hi = 0; r.lo = 0; r.lat = 3; end
    else begin
      qq = x / y; rr = x % y;
      r.lo = qq[31:0]; r.hi = rr[31:0]; r.lat = 34;
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic comb(input logic [7:0] op, input logic [2:0] sel,
                      input logic [31:0] a, input logic [31:0] b);
    aluop = op; alusel = sel; reg1 = a; reg2 = b;
    hi = $urandom; lo = $urandom; we = 1'($urandom); waddr = 5'($urandom);
    cv = 1;
    comb_q.push_back(cmodel(op, sel, a, b, hi, lo, we, waddr));
    @(posedge clk); #1;
  endtask

  task automatic div_drive(input logic s, input logic [31:0] a, input logic [31:0] b);
    aluop = s ? O_DIV : O_DIVU; alusel = S_DIV; reg1 = a; reg2 = b;
    we = 1'($urandom); waddr = 5'($urandom); cv = 0;
  endtask

  task automatic div_wait();
    int start;
    bit ok;
    start = done_cnt;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done_cnt != start) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL div_timeout: no whilo_o within 60 cycles (op=%h a=%h b=%h)", aluop, reg1, reg2);
      div_q.delete();
    end
  endtask

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    div_drive(s, a, b);
    div_q.push_back(dmodel(s, a, b));
    div_wait();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ({wdata_o, waddr_o, we_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: wdata=%h waddr=%h we=%b whilo=%b hi=%h lo=%h stall=%b, want all 0",
                 wdata_o, waddr_o, we_o, whilo_o, hi_o, lo_o, stallreq_o);
      end
      div_q.delete();
      dcyc = 0; dstall = 0;
    end else begin
      if (cv) begin
        comb_t e;
        checks++;
        if (comb_q.size() == 0) begin
          failures++;
          $display("FAIL comb_underflow: output presented with no expectation");
        end else begin
          e = comb_q.pop_front();
          if ((e.care && wdata_o !== e.wdata) || we_o !== e.we || waddr_o !== e.waddr ||
              stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
            failures++;
            $display("FAIL comb op=%h sel=%0d a=%h b=%h: got wdata=%h we=%b waddr=%h stall=%b whilo=%b, want wdata=%h we=%b waddr=%h stall=0 whilo=0",
                     aluop, alusel, reg1, reg2, wdata_o, we_o, waddr_o, stallreq_o, whilo_o,
                     e.wdata, e.we, e.waddr);
          end
        end
      end
      if (alusel == S_DIV) begin
        dcyc++;
        dstall += int'(stallreq_o);
        checks++;
        if (we_o !== 1'b0) begin
          failures++;
          $display("FAIL div_we: got we_o=%b, want 0", we_o);
        end
      end
      if (whilo_o) begin
        div_t d;
        checks++;
        if (div_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_whilo: got whilo_o=1 hi=%h lo=%h, want no pulse", hi_o, lo_o);
        end else begin
          d = div_q.pop_front();
          if (hi_o !== d.hi || lo_o !== d.lo || dcyc != d.lat || dstall != d.lat - 1) begin
            failures++;
            $display("FAIL div a=%h b=%h op=%h: got hi=%h lo=%h latency=%0d stall=%0d, want hi=%h lo=%h latency=%0d stall=%0d",
                     reg1, reg2, aluop, hi_o, lo_o, dcyc, dstall, d.hi, d.lo, d.lat, d.lat - 1);
          end
        end
        dcyc = 0; dstall = 0;
        done_cnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [19];
    logic [2:0] sels [19];
    int k;
    ops  = '{O_OR, O_AND, O_XOR, O_NOR, O_SLL, O_SRL, O_SRA, O_ADD, O_ADDU, O_SUB,
             O_SUBU, O_SLT, O_SLTU, O_MFHI, O_MFLO, 8'hFF, 8'h5A, 8'h00, O_ADD};
    sels = '{S_LOGIC, S_LOGIC, S_LOGIC, S_LOGIC, S_SHIFT, S_SHIFT, S_SHIFT, S_ARITH, S_ARITH,
             S_ARITH, S_ARITH, S_ARITH, S_ARITH, S_MOVE, S_MOVE, S_LOGIC, S_SHIFT, S_NOP, 3'd6};
    aluop = O_OR; alusel = S_LOGIC; reg1 = 32'h1234; reg2 = 32'h5678; we = 1; waddr = 5'd5;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    comb(O_OR, S_LOGIC, 32'h0000FF00, 32'h00F0000F);
    comb(O_SRA, S_SHIFT, 32'd4, 32'h80000010);
    comb(O_SLT, S_ARITH, 32'hFFFFFFFF, 32'd1);
    comb(O_SLTU, S_ARITH, 32'hFFFFFFFF, 32'd1);
    comb(O_ADD, S_ARITH, 32'h7FFFFFFF, 32'd1);
    comb(O_ADDU, S_ARITH, 32'h7FFFFFFF, 32'd1);
    comb(O_SUB, S_ARITH, 32'd0, 32'h80000000);
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 18);
      comb(ops[k], sels[k], rnd32(), rnd32());
    end
    do_div(1, 32'hFFFFFFF9, 32'd2);
    do_div(0, 32'hFFFFFFFF, 32'd0);
    do_div(1, 32'h80000000, 32'hFFFFFFFF);
    do_div(1, 32'd7, 32'hFFFFFFFE);
    do_div(1, 32'h12345678, 32'd0);
    do_div(0, 32'hFFFFFFFF, 32'd1);
    for (int i = 0; i < 12; i++) do_div(1'($urandom), rnd32(), rnd32());
    div_drive(1, $urandom, 32'd3);
    repeat (11) begin @(posedge clk); #1; end
    rst = 1;
    div_drive(0, 32'd100, 32'd7);
    @(posedge clk); #1;
    rst = 0;
    div_q.push_back(dmodel(0, 32'd100, 32'd7));
    div_wait();
    comb(O_MFLO, S_MOVE, 32'd0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(0, 18);
      comb(ops[k], sels[k], rnd32(), rnd32());
    end
    cv = 0; alusel = S_NOP; aluop = 0;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 aluop_i  input  8 (`AluOpBus)  operation code from the ID/EX register.
REQ-004 alusel_i  input  3 (`AluSelBus)  result class: NOP, LOGIC, SHIFT, ARITH, MOVE, DIV.
REQ-005 reg1_i, reg2_i  input  32 each  source operands.
REQ-006 waddr_i  input  5  destination GPR; we_i  input  1  GPR write request.
REQ-007 hi_i, lo_i  input  32 each  current HILO contents.
REQ-008 wdata_o  output  32  GPR write data.
REQ-009 waddr_o  output  5  destination GPR, passed through.
REQ-010 we_o  output  1  GPR write enable.
REQ-011 whilo_o  output  1  HILO write enable.
REQ-012 hi_o, lo_o  output  32 each  HILO write data.
REQ-013 stallreq_o  output  1  stall request to ctrl; ctrl then holds stages 0-3.

Function
REQ-014 LOGIC class SHALL produce OR, AND, XOR and NOR of reg1_i and reg2_i, combinationally in the same cycle.
REQ-015 SHIFT class SHALL produce SLL, SRL and SRA of reg2_i by reg1_i[4:0]; SRA fills vacated bits with reg2_i[31].
REQ-016 ARITH class SHALL produce ADD/ADDU/SUB/SUBU as 32-bit modular sums, SLT as a signed compare and SLTU as an unsigned compare; SLT/SLTU results are 0 or 1.
REQ-017 ADD/SUB signed overflow SHALL force we_o=0; wdata_o is don't-care in that case.
REQ-018 MOVE class SHALL output hi_i for MFHI and lo_i for MFLO on wdata_o.
REQ-019 NOP class or an unknown aluop SHALL give wdata_o=0; waddr_o and we_o still pass through.
REQ-020 For every non-DIV class: whilo_o=0, stallreq_o=0, and latency is 0 cycles (combinational).
REQ-021 DIV/DIVU SHALL use a divider FSM with states IDLE, ON, ZERO and END.
REQ-022 IDLE, DIV op present: go to ZERO if reg2_i=0, else go to ON, latching |dividend| and |divisor| (raw values for DIVU), clearing the 6-bit counter and asserting stallreq_o.
REQ-023 ON: perform one restoring-division step per cycle and increment the counter; after the 32nd step go to END; stallreq_o=1.
REQ-024 ZERO: one cycle with stallreq_o=1, then END with quotient=0 and remainder=0.
REQ-025 END: stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder; next state is IDLE regardless of inputs.
REQ-026 Signed DIV: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
REQ-027 DIV ops SHALL hold we_o=0 in all states.
REQ-028 Total DIV latency SHALL be 34 cycles from the first IDLE-with-DIV cycle to END (IDLE, 32x ON, END); divide-by-zero takes 3 cycles.
REQ-029 Operands are held stable by the stall while the FSM is busy; the FSM SHALL sample them only in IDLE.
REQ-030 A DIV in END followed by a DIV in the next cycle SHALL start a new division from IDLE; no result is reused.

Reset
REQ-031 While rst=1: FSM goes to IDLE, counter=0, and all outputs are forced to 0 (waddr_o=`NOPRegAddr, we_o=`WriteDisable).
REQ-032 Reset asserted mid-division SHALL abort it with no whilo_o pulse; the first cycle after reset is IDLE.

Verification
REQ-033 OR 0x0000FF00 with 0x00F0000F -> wdata_o=0x00F0FF0F, we_o follows we_i, stallreq_o=0.
REQ-034 SRA reg2=0x80000010, shamt 4 -> 0xF8000001; SLT -1 vs 1 -> 1; SLTU with the same operands -> 0.
REQ-035 ADD 0x7FFFFFFF+1 -> we_o=0; ADDU with the same operands -> we_o=1, wdata_o=0x80000000.
REQ-036 DIV -7 / 2 -> stallreq_o high for 33 cycles, then END: lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, whilo_o=1 for exactly one cycle.
REQ-037 DIVU 0xFFFFFFFF / 0 -> ZERO path, END on cycle 3 with hi_o=lo_o=0, whilo_o=1.
REQ-038 rst pulsed at ON count 10 -> no whilo_o pulse; a following DIVU 100/7 -> lo_o=14, hi_o=2.
